// File: rtl/mesh_noc_pkg.sv
// Shared mesh NoC types: port count, port indices, allocator states.
// Port-index helpers used by the allocators and the routing logic.
package mesh_noc_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_N     = 3'd1;
  localparam logic [2:0] P_E     = 3'd2;
  localparam logic [2:0] P_S     = 3'd3;
  localparam logic [2:0] P_W     = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } st_e;

  // (p + k) mod NPORTS for p, k < NPORTS
  function automatic logic [2:0] port_add(
    input logic [2:0] p,
    input logic [2:0] k
  );
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 4'(NPORTS))
      s = s - 4'(NPORTS);
    return s[2:0];
  endfunction

endpackage

// File: rtl/mesh_out_arbiter_if.sv
// Output-port allocator bundle: master = input side, slave = allocator.
// req/tail/credit_in in; gnt/fire/locked/cnt/pkt_cnt/err_ovf out.
interface mesh_out_arbiter_if #(
  parameter int CREDITS = 4
);
  import mesh_noc_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] tail;
  logic              credit_in;
  logic [NPORTS-1:0] gnt;
  logic              fire;
  logic              locked;
  logic [CW-1:0]     cnt;
  logic [7:0]        pkt_cnt;
  logic              err_ovf;

  modport master (
    output req, tail, credit_in,
    input  gnt, fire, locked, cnt, pkt_cnt, err_ovf
  );

  modport slave (
    input  req, tail, credit_in,
    output gnt, fire, locked, cnt, pkt_cnt, err_ovf
  );

endinterface

// File: rtl/mesh_rr_pick.sv
// Rotate-priority picker: first req at or after ptr, wrapping.
// In: req, ptr. Out: one-hot winner, winner index.
module mesh_rr_pick
  import mesh_noc_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [2:0]        ptr,
  output logic [NPORTS-1:0] oh,
  output logic [2:0]        idx
);

  logic       found;
  logic [2:0] cand;

  always_comb begin
    oh    = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = port_add(ptr, 3'(k));
      if (!found && req[cand]) begin
        found    = 1'b1;
        oh[cand] = 1'b1;
        idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mesh_out_arbiter.sv
// Per-output switch allocator: round-robin, packet lock, credit gating.
// Ports: clk, reset (sync active-low), bus (slave modport).
module mesh_out_arbiter
  import mesh_noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input logic               clk,
  input logic               reset,
  mesh_out_arbiter_if.slave bus
);

  localparam int CW = $clog2(CREDITS + 1);

  st_e               st;
  logic [2:0]        owner;
  logic [2:0]        ptr;
  logic [CW-1:0]     cnt;
  logic [7:0]        pkt_cnt;
  logic              err_ovf;

  logic [NPORTS-1:0] pick_oh;
  logic [2:0]        pick_idx;
  logic [NPORTS-1:0] gnt_c;
  logic              fire_c;
  logic              tail_c;
  logic [2:0]        win;

  mesh_rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr),
    .oh  (pick_oh),
    .idx (pick_idx)
  );

  // Lock holds gnt on owner even when its req drops (bubble).
  always_comb begin
    gnt_c  = '0;
    fire_c = 1'b0;
    win    = (st == ST_IDLE) ? pick_idx : owner;
    tail_c = bus.tail[win];
    if (reset && cnt != '0) begin
      if (st == ST_IDLE) begin
        gnt_c  = pick_oh;
        fire_c = |pick_oh;
      end else begin
        for (int i = 0; i < NPORTS; i++)
          gnt_c[i] = (owner == 3'(i));
        fire_c = bus.req[owner];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st      <= ST_IDLE;
      owner   <= P_LOCAL;
      ptr     <= P_LOCAL;
      cnt     <= CW'(CREDITS);
      pkt_cnt <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (fire_c) begin
        if (tail_c) begin
          st      <= ST_IDLE;
          ptr     <= port_add(win, 3'd1);
          pkt_cnt <= pkt_cnt + 8'd1;
        end else if (st == ST_IDLE) begin
          st    <= ST_LOCKED;
          owner <= win;
        end
      end
      unique case ({fire_c, bus.credit_in})
        2'b10: cnt <= cnt - CW'(1);
        2'b01: begin
          if (cnt == CW'(CREDITS))
            err_ovf <= 1'b1;
          else
            cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.fire    = fire_c;
  assign bus.locked  = (st == ST_LOCKED);
  assign bus.cnt     = cnt;
  assign bus.pkt_cnt = pkt_cnt;
  assign bus.err_ovf = err_ovf;

endmodule

// File: tb/tb_mesh_out_arbiter.sv
// Directed bench for mesh_out_arbiter.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_mesh_out_arbiter;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  mesh_out_arbiter_if #(.CREDITS(4)) bus ();

  mesh_out_arbiter #(.CREDITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [4:0] r, input logic [4:0] t,
                       input logic c);
    @(negedge clk);
    bus.req = r;
    bus.tail = t;
    bus.credit_in = c;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(5'b11111, 5'b00000, 1'b0);
      vecs++; if (bus.gnt !== 5'b0) begin errs++; $display("FAIL rst_gnt: got %b want 00000", bus.gnt); end
      vecs++; if (bus.fire !== 1'b0) begin errs++; $display("FAIL rst_fire: got %b want 0", bus.fire); end
    end
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    #1;
    vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL rst_cnt: got %0d want 4", bus.cnt); end
    vecs++; if (bus.gnt !== 5'b0) begin errs++; $display("FAIL idle_gnt: got %b want 00000", bus.gnt); end
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL rst_locked: got %b want 0", bus.locked); end
    vecs++; if (bus.pkt_cnt !== 8'd0) begin errs++; $display("FAIL rst_pkt: got %0d want 0", bus.pkt_cnt); end
    vecs++; if (bus.err_ovf !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", bus.err_ovf); end
  endtask

  task automatic test_round_robin;
    logic [4:0] e [6];
    e = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    for (int i = 0; i < 6; i++) begin
      drive(5'b11111, 5'b11111, 1'b1);
      vecs++; if (bus.gnt !== e[i]) begin errs++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt, e[i]); end
      vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL rr_cnt[%0d]: got %0d want 4", i, bus.cnt); end
    end
    drive(5'b0, 5'b0, 1'b0);
    vecs++; if (bus.pkt_cnt !== 8'd6) begin errs++; $display("FAIL rr_pkt: got %0d want 6", bus.pkt_cnt); end
    vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL rr_cnt_end: got %0d want 4", bus.cnt); end
  endtask

  task automatic test_packet_lock;
    drive(5'b00010, 5'b00010, 1'b1);
    vecs++; if (bus.gnt !== 5'b00010) begin errs++; $display("FAIL lk_pre: got %b want 00010", bus.gnt); end
    for (int i = 0; i < 3; i++) begin
      drive(5'b01110, (i == 2) ? 5'b00100 : 5'b00000, 1'b1);
      vecs++; if (bus.gnt !== 5'b00100) begin errs++; $display("FAIL lk_gnt[%0d]: got %b want 00100", i, bus.gnt); end
      vecs++; if (bus.fire !== 1'b1) begin errs++; $display("FAIL lk_fire[%0d]: got %b want 1", i, bus.fire); end
      if (i > 0) begin
        vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL lk_locked[%0d]: got %b want 1", i, bus.locked); end
      end
    end
    drive(5'b01010, 5'b01010, 1'b1);
    vecs++; if (bus.gnt !== 5'b01000) begin errs++; $display("FAIL lk_next: got %b want 01000", bus.gnt); end
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL lk_unlock: got %b want 0", bus.locked); end
    vecs++; if (bus.pkt_cnt !== 8'd8) begin errs++; $display("FAIL lk_pkt: got %0d want 8", bus.pkt_cnt); end
  endtask

  task automatic test_credit_stall;
    for (int i = 0; i < 4; i++) begin
      drive(5'b00001, 5'b0, 1'b0);
      vecs++; if (bus.gnt !== 5'b00001) begin errs++; $display("FAIL cs_gnt[%0d]: got %b want 00001", i, bus.gnt); end
      vecs++; if (bus.cnt !== 3'(4 - i)) begin errs++; $display("FAIL cs_cnt[%0d]: got %0d want %0d", i, bus.cnt, 4 - i); end
    end
    drive(5'b00001, 5'b0, 1'b1);
    vecs++; if (bus.gnt !== 5'b0) begin errs++; $display("FAIL cs_stall_gnt: got %b want 00000", bus.gnt); end
    vecs++; if (bus.fire !== 1'b0) begin errs++; $display("FAIL cs_stall_fire: got %b want 0", bus.fire); end
    vecs++; if (bus.cnt !== 3'd0) begin errs++; $display("FAIL cs_stall_cnt: got %0d want 0", bus.cnt); end
    vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL cs_stall_lock: got %b want 1", bus.locked); end
    drive(5'b00001, 5'b0, 1'b0);
    vecs++; if (bus.fire !== 1'b1) begin errs++; $display("FAIL cs_one_fire: got %b want 1", bus.fire); end
    vecs++; if (bus.cnt !== 3'd1) begin errs++; $display("FAIL cs_one_cnt: got %0d want 1", bus.cnt); end
    drive(5'b00001, 5'b0, 1'b1);
    vecs++; if (bus.fire !== 1'b0) begin errs++; $display("FAIL cs_only_one: got %b want 0", bus.fire); end
    drive(5'b00001, 5'b00001, 1'b0);
    vecs++; if (bus.fire !== 1'b1) begin errs++; $display("FAIL cs_tail_fire: got %b want 1", bus.fire); end
    drive(5'b0, 5'b0, 1'b1);
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL cs_unlock: got %b want 0", bus.locked); end
    vecs++; if (bus.pkt_cnt !== 8'd10) begin errs++; $display("FAIL cs_pkt: got %0d want 10", bus.pkt_cnt); end
    vecs++; if (bus.cnt !== 3'd0) begin errs++; $display("FAIL cs_empty: got %0d want 0", bus.cnt); end
    repeat (3) drive(5'b0, 5'b0, 1'b1);
    drive(5'b0, 5'b0, 1'b0);
    vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL cs_refill: got %0d want 4", bus.cnt); end
  endtask

  task automatic test_owner_bubble;
    drive(5'b10001, 5'b0, 1'b1);
    vecs++; if (bus.gnt !== 5'b10000) begin errs++; $display("FAIL ob_head: got %b want 10000", bus.gnt); end
    for (int i = 0; i < 2; i++) begin
      drive(5'b00001, 5'b0, 1'b0);
      vecs++; if (bus.gnt !== 5'b10000) begin errs++; $display("FAIL ob_gnt[%0d]: got %b want 10000", i, bus.gnt); end
      vecs++; if (bus.fire !== 1'b0) begin errs++; $display("FAIL ob_fire[%0d]: got %b want 0", i, bus.fire); end
      vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL ob_cnt[%0d]: got %0d want 4", i, bus.cnt); end
    end
    drive(5'b10000, 5'b10000, 1'b1);
    vecs++; if (bus.fire !== 1'b1) begin errs++; $display("FAIL ob_tail: got %b want 1", bus.fire); end
    vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL ob_cnt_end: got %0d want 4", bus.cnt); end
    drive(5'b0, 5'b0, 1'b0);
    vecs++; if (bus.pkt_cnt !== 8'd11) begin errs++; $display("FAIL ob_pkt: got %0d want 11", bus.pkt_cnt); end
  endtask

  task automatic test_edge_cases;
    drive(5'b0, 5'b0, 1'b1);
    vecs++; if (bus.err_ovf !== 1'b0) begin errs++; $display("FAIL ov_pre: got %b want 0", bus.err_ovf); end
    drive(5'b0, 5'b0, 1'b0);
    vecs++; if (bus.err_ovf !== 1'b1) begin errs++; $display("FAIL ov_set: got %b want 1", bus.err_ovf); end
    vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL ov_cnt: got %0d want 4", bus.cnt); end
    drive(5'b0, 5'b0, 1'b0);
    vecs++; if (bus.err_ovf !== 1'b1) begin errs++; $display("FAIL ov_sticky: got %b want 1", bus.err_ovf); end
    drive(5'b00010, 5'b0, 1'b0);
    vecs++; if (bus.gnt !== 5'b00010) begin errs++; $display("FAIL mr_head: got %b want 00010", bus.gnt); end
    drive(5'b00010, 5'b0, 1'b0);
    vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL mr_locked: got %b want 1", bus.locked); end
    vecs++; if (bus.cnt !== 3'd3) begin errs++; $display("FAIL mr_cnt: got %0d want 3", bus.cnt); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++; if (bus.gnt !== 5'b0) begin errs++; $display("FAIL mr_rst_gnt: got %b want 00000", bus.gnt); end
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    #1;
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL mr_idle: got %b want 0", bus.locked); end
    vecs++; if (bus.cnt !== 3'd4) begin errs++; $display("FAIL mr_cnt_rl: got %0d want 4", bus.cnt); end
    vecs++; if (bus.pkt_cnt !== 8'd0) begin errs++; $display("FAIL mr_pkt: got %0d want 0", bus.pkt_cnt); end
    drive(5'b00011, 5'b00011, 1'b1);
    vecs++; if (bus.gnt !== 5'b00001) begin errs++; $display("FAIL mr_ptr: got %b want 00001", bus.gnt); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b0;
    bus.req = '0;
    bus.tail = '0;
    bus.credit_in = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_stall();
    test_owner_bubble();
    test_edge_cases();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mesh_out_arbiter.md
# mesh_out_arbiter

Per-output-port switch allocator for a mesh router. It shares one router output link among five input requesters (Local, N, E, S, W) using round-robin arbitration. A grant is locked for the duration of a packet (head flit through tail flit), and flits are forwarded only while downstream credits remain. One instance sits on each of the five output ports of every mesh router, between the input FIFOs and the output crossbar mux select.

## Interface
- NPORTS, 5, number of requesting input ports (index 0 = Local, 1 = N, 2 = E, 3 = S, 4 = W)
- CREDITS, 4, downstream FIFO depth in flits; also the reset value of the credit counter
- CW, $clog2(CREDITS+1), credit counter width

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge
- req  in  NPORTS  req[i]=1: input i has a valid flit at its FIFO head routed to this output
- tail  in  NPORTS  tail[i]=1: the flit offered on input i is the last flit of its packet; only meaningful when req[i]=1
- credit_in  in  1  one downstream slot freed this cycle
- gnt  out  NPORTS  one-hot or zero; drives the crossbar select and the pop of input i
- fire  out  1  a flit transfers this cycle; equals |(gnt & req) when cnt>0
- locked  out  1  allocator is mid-packet
- cnt  out  CW  current credits
- pkt_cnt  out  8  packets completed, modulo 256
- err_ovf  out  1  sticky; credit_in arrived while cnt==CREDITS

## Operation
- State: IDLE or LOCKED. Registers: owner (3 b), ptr (3 b), cnt, pkt_cnt, err_ovf.
- IDLE:
  - If cnt>0 and req≠0, gnt = one-hot of the first i with req[i]=1, searching ptr, ptr+1, … mod NPORTS. That flit fires in the same cycle.
  - If cnt==0, gnt=0 and nothing fires.
- Fire in IDLE with tail=0: go to LOCKED, owner ← winner.
- Fire in IDLE with tail=1 (single-flit packet): stay in IDLE, ptr ← (winner+1) mod NPORTS, pkt_cnt++.
- LOCKED:
  - gnt = one-hot(owner) whenever cnt>0, regardless of req. Other requesters are ignored.
  - Fire happens when req[owner]=1 and cnt>0.
  - If req[owner] drops, gnt holds, no fire occurs (bubble), and the lock is kept.
- Fire in LOCKED with tail[owner]=1: go to IDLE, ptr ← (owner+1) mod NPORTS, pkt_cnt++.
- Credits: on each clock edge, cnt ← cnt − fire + credit_in.
  - Fire and credit_in in the same cycle: cnt unchanged.
  - credit_in at cnt==CREDITS with no fire: cnt stays at CREDITS and err_ovf ← 1.
  - cnt never underflows, because fire requires cnt>0.
- pkt_cnt wraps 255 → 0 silently.

## Timing
- gnt and fire are combinational from registered state plus req/tail, with zero-cycle arbitration latency. The head flit transfers in the same cycle its req is first seen, provided the port wins and cnt>0.
- All state updates on the clk rising edge.
- Reset (reset=0 at an edge):
  - state=IDLE, owner=0, ptr=0, cnt=CREDITS, pkt_cnt=0, err_ovf=0.
  - gnt=0 and fire=0 while reset is low.
- Reset mid-packet: the lock is dropped with no tail and the credits reload. The packet is not counted.
- Throughput: one flit per cycle while credits last. There is no dead cycle between the tail of one packet and the head of the next.

## Structure
- Package mesh_noc_pkg:
  - NPORTS.
  - Port index constants P_LOCAL=0, P_N=1, P_E=2, P_S=3, P_W=4.
  - State encoding ST_IDLE=0, ST_LOCKED=1.
  - The same package is shared by the routing and FIFO blocks.
- Sub-module mesh_rr_pick: combinational rotate-priority picker. Inputs are req and ptr; outputs are the one-hot winner and its index.
- The top level holds the FSM, the credit counter, pkt_cnt and err_ovf.

## Test plan
- Reset and idle:
  - Stimulus: reset=0 for 2 cycles, then reset=1 with req=0.
  - Required: cnt=4, gnt=0, locked=0, pkt_cnt=0, err_ovf=0.
- Round-robin, single-flit packets:
  - Stimulus: req=5'b11111 and tail=5'b11111 for 6 cycles, credit_in=1 every cycle.
  - Required: gnt sequence 00001, 00010, 00100, 01000, 10000, 00001; pkt_cnt=6; cnt stays at 4.
- Packet lock:
  - Stimulus: port 2 sends a 3-flit packet (tail on the 3rd flit) while req[1] is held high throughout.
  - Required: gnt=00100 for 3 fires, with locked=1 across them. In the next cycle gnt=01000 if req[3] is high, otherwise 00010 (ptr=3).
- Credit stall:
  - Stimulus: no credit_in; port 0 sends a 6-flit packet.
  - Required: 4 fires, then cnt=0 and gnt=0 with locked held. One credit_in pulse causes exactly one more fire in the following cycle.
- Owner bubble:
  - Stimulus: locked to port 4; req[4] drops for 2 cycles while req[0] is high.
  - Required: gnt stays 10000, fire=0, and cnt is unchanged during those 2 cycles.
- Edge cases:
  - Stimulus: credit_in at cnt=4 with no fire; separately, assert reset mid-packet.
  - Required: err_ovf=1 and stays set. After the reset, state=IDLE, cnt=4, and pkt_cnt is unchanged from 0.
